// File: rtl/gb_audio_pkg.sv
// Shared constants for the Game Boy style audio channels: timebase ratio,
// envelope rate, sample format and the pulse duty patterns.
package gb_audio_pkg;

    localparam int GB_TB_NUM   = 32;
    localparam int GB_TB_DEN   = 375;
    localparam int ENV_DIV     = 16384;
    localparam int SCALE_SHIFT = 14;
    localparam int SAMPLE_W    = 20;
    localparam int VOL_W       = 4;
    localparam int FREQ_W      = 11;
    localparam int STEP_W      = 3;

    // Indexed as DUTY_TABLE[duty][step]; entry 0 is the rightmost literal.
    localparam logic [3:0][7:0] DUTY_TABLE = {
        8'b0111_1110,
        8'b1000_0111,
        8'b1000_0001,
        8'b0000_0001
    };

endpackage

// File: rtl/gb_timebase.sv
// Fractional clock divider: emits gb_tick on NUM out of every DEN clock cycles
// with no accumulated drift.
module gb_timebase
    import gb_audio_pkg::*;
#(
    parameter int NUM = GB_TB_NUM,
    parameter int DEN = GB_TB_DEN
) (
    input  logic clk,
    input  logic srst,
    output logic gb_tick
);

    localparam int ACC_W = $clog2(DEN + NUM);

    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W:0]   sum;

    always_comb begin
        sum     = {1'b0, acc_reg} + (ACC_W+1)'(NUM);
        gb_tick = (sum >= (ACC_W+1)'(DEN));
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            acc_reg <= '0;
        end else if (gb_tick) begin
            acc_reg <= ACC_W'(sum - (ACC_W+1)'(DEN));
        end else begin
            acc_reg <= sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/gb_square_channel.sv
// Game Boy pulse channel: duty sequencer, period timer and volume envelope,
// producing one signed PCM sample per frame strobe.
module gb_square_channel
    import gb_audio_pkg::*;
#(
    parameter int TB_NUM      = GB_TB_NUM,
    parameter int TB_DEN      = GB_TB_DEN,
    parameter int ENV_DIV     = gb_audio_pkg::ENV_DIV,
    parameter int SCALE_SHIFT = gb_audio_pkg::SCALE_SHIFT
) (
    input  logic                ac97_bitclk,
    input  logic                reset,
    input  logic                strobe,
    input  logic                square_wave_enable,
    input  logic                trigger,
    input  logic [1:0]          duty,
    input  logic [FREQ_W-1:0]   freq,
    input  logic [VOL_W-1:0]    env_init,
    input  logic                env_up,
    input  logic [2:0]          env_period,
    output logic [SAMPLE_W-1:0] square_sample,
    output logic                sample_valid
);

    localparam int ENV_DIV_W = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;

    logic                 gb_tick;
    logic                 env_fire;
    logic                 active_reg;
    logic [STEP_W-1:0]    step_reg;
    logic [FREQ_W-1:0]    timer_reg;
    logic [VOL_W-1:0]     volume_reg;
    logic [2:0]           env_cnt_reg;
    logic [ENV_DIV_W-1:0] env_div_reg;
    logic [SAMPLE_W-1:0]  square_sample_reg;
    logic                 sample_valid_reg;
    logic [FREQ_W-1:0]    reload_value;
    logic [SAMPLE_W-1:0]  magnitude;
    logic [SAMPLE_W-1:0]  sample_next;

    gb_timebase #(
        .NUM (TB_NUM),
        .DEN (TB_DEN)
    ) u_timebase (
        .clk     (ac97_bitclk),
        .srst    (reset),
        .gb_tick (gb_tick)
    );

    always_comb begin
        reload_value = FREQ_W'(12'd2048 - {1'b0, freq});
        env_fire     = gb_tick && (env_div_reg == ENV_DIV_W'(ENV_DIV - 1));
        magnitude    = SAMPLE_W'(volume_reg) << SCALE_SHIFT;
        sample_next  = '0;
        if (square_wave_enable && active_reg) begin
            sample_next = DUTY_TABLE[duty][step_reg] ? magnitude : -magnitude;
        end
    end

    // The envelope divider free-runs so retriggering never shifts the 64 Hz grid.
    always_ff @(posedge ac97_bitclk) begin
        if (reset) begin
            env_div_reg <= '0;
        end else if (gb_tick) begin
            env_div_reg <= env_fire ? '0 : env_div_reg + 1'b1;
        end
    end

    always_ff @(posedge ac97_bitclk) begin
        if (reset) begin
            active_reg <= 1'b0;
            step_reg   <= '0;
            timer_reg  <= '0;
        end else if (trigger) begin
            active_reg <= 1'b1;
            step_reg   <= '0;
            timer_reg  <= reload_value;
        end else if (active_reg && gb_tick) begin
            if (timer_reg <= FREQ_W'(1)) begin
                timer_reg <= reload_value;
                step_reg  <= step_reg + 1'b1;
            end else begin
                timer_reg <= timer_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge ac97_bitclk) begin
        if (reset) begin
            volume_reg  <= '0;
            env_cnt_reg <= '0;
        end else if (trigger) begin
            volume_reg  <= env_init;
            env_cnt_reg <= env_period;
        end else if (active_reg && env_fire && (env_period != 3'd0)) begin
            if (env_cnt_reg <= 3'd1) begin
                env_cnt_reg <= env_period;
                if (env_up && (volume_reg != {VOL_W{1'b1}})) begin
                    volume_reg <= volume_reg + 1'b1;
                end else if (!env_up && (volume_reg != '0)) begin
                    volume_reg <= volume_reg - 1'b1;
                end
            end else begin
                env_cnt_reg <= env_cnt_reg - 1'b1;
            end
        end
    end

    // Sampling sees pre-trigger / pre-advance state because it reads the registers.
    always_ff @(posedge ac97_bitclk) begin
        if (reset) begin
            square_sample_reg <= '0;
            sample_valid_reg  <= 1'b0;
        end else begin
            sample_valid_reg <= strobe;
            if (strobe) begin
                square_sample_reg <= sample_next;
            end
        end
    end

    assign square_sample = square_sample_reg;
    assign sample_valid  = sample_valid_reg;

endmodule

// File: tb/tb_gb_square_channel.sv
// Directed bench for gb_square_channel: a per-cycle behavioural model plus
// hand-computed literal expectations for each scenario.
module tb_gb_square_channel;

    localparam int ENV_DIV_T = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        strobe = 1'b0;
    logic        square_wave_enable = 1'b0;
    logic        trigger = 1'b0;
    logic [1:0]  duty = 2'd0;
    logic [10:0] freq = 11'd0;
    logic [3:0]  env_init = 4'd0;
    logic        env_up = 1'b0;
    logic [2:0]  env_period = 3'd0;
    logic [19:0] square_sample;
    logic        sample_valid;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    gb_square_channel #(.ENV_DIV(ENV_DIV_T)) dut (
        .ac97_bitclk        (clk),
        .reset              (reset),
        .strobe             (strobe),
        .square_wave_enable (square_wave_enable),
        .trigger            (trigger),
        .duty               (duty),
        .freq               (freq),
        .env_init           (env_init),
        .env_up             (env_up),
        .env_period         (env_period),
        .square_sample      (square_sample),
        .sample_valid       (sample_valid)
    );

    always #5 clk = ~clk;

    // Behavioural model: tick times from cycle arithmetic, duty from step lists.
    int duty_hi [4][8] = '{'{1,0,0,0,0,0,0,0}, '{1,0,0,0,0,0,0,1},
                           '{1,1,1,0,0,0,0,1}, '{0,1,1,1,1,1,1,0}};
    longint m_cyc;
    int m_ticks, m_fires, m_step, m_timer, m_vol, m_env_cnt, m_strobe_step;
    int m_sample;
    bit m_active, m_valid;

    always @(posedge clk) begin
        bit tick, fire;
        if (reset) begin
            m_cyc = 0; m_ticks = 0; m_active = 0; m_step = 0; m_timer = 0;
            m_vol = 0; m_env_cnt = 0; m_sample = 0; m_valid = 0;
        end else begin
            tick = (((m_cyc * 32) % 375) + 32) >= 375;
            m_cyc++;
            m_valid = strobe;
            if (strobe) begin
                m_strobe_step = m_step;
                if (!square_wave_enable || !m_active) m_sample = 0;
                else m_sample = duty_hi[duty][m_step] ? m_vol * 16384 : -(m_vol * 16384);
            end
            fire = 0;
            if (tick) begin
                m_ticks++;
                fire = (m_ticks % ENV_DIV_T) == 0;
                if (fire) m_fires++;
            end
            if (trigger) begin
                m_active = 1; m_step = 0; m_timer = (2048 - int'(freq)) % 2048;
                m_vol = int'(env_init); m_env_cnt = int'(env_period);
            end else if (m_active) begin
                if (tick) begin
                    if (m_timer <= 1) begin
                        m_timer = (2048 - int'(freq)) % 2048;
                        m_step = (m_step + 1) % 8;
                    end else m_timer--;
                end
                if (fire && env_period != 0) begin
                    if (m_env_cnt <= 1) begin
                        m_env_cnt = int'(env_period);
                        if (env_up && m_vol < 15) m_vol++;
                        else if (!env_up && m_vol > 0) m_vol--;
                    end else m_env_cnt--;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (int'($signed(square_sample)) != m_sample || sample_valid != m_valid) begin
                errors++;
                $display("FAIL model_cmp t=%0t sample=%0d valid=%0b required sample=%0d valid=%0b",
                         $time, $signed(square_sample), sample_valid, m_sample, m_valid);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end else begin
            $display("ok   %s value=%0d", name, act);
        end
    endtask

    function automatic int sample_int();
        return int'($signed(square_sample));
    endfunction

    function automatic int sample_mag();
        int v = int'($signed(square_sample));
        return (v < 0) ? -v : v;
    endfunction

    task automatic pulse_strobe();
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic wait_fire();
        int start = m_fires;
        for (int i = 0; i < 1000 && m_fires == start; i++) @(negedge clk);
        checks++;
        if (m_fires == start) begin
            errors++;
            $display("FAIL wait_fire timeout actual=none required=envelope tick");
        end
    endtask

    initial begin
        int tick_cnt;
        int exp;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("reset_sample", sample_int(), 0);
        check("reset_valid", int'(sample_valid), 0);
        reset = 1'b0;

        // Timebase: 3750 cycles must produce exactly 320 ticks and wrap the accumulator.
        tick_cnt = 0;
        for (int i = 0; i < 3750; i++) begin
            if (dut.u_timebase.gb_tick) tick_cnt++;
            @(negedge clk);
        end
        check("tb_ticks_3750", tick_cnt, 320);
        check("tb_acc_zero", int'(dut.u_timebase.acc_reg), 0);

        // Period: step advances every tick; duty 10 is high on steps 0,1,2,7.
        square_wave_enable = 1'b1;
        freq = 11'd2047; duty = 2'd2; env_init = 4'd15; env_period = 3'd0; env_up = 1'b0;
        pulse_trigger();
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < (i % 4) * 3; j++) @(negedge clk);
            pulse_strobe();
            exp = (m_strobe_step inside {0, 1, 2, 7}) ? 245760 : -245760;
            check($sformatf("period_step%0d", m_strobe_step), sample_int(), exp);
        end

        // Enable low silences the output; phase keeps running.
        square_wave_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pulse_strobe();
            check("disabled_zero", sample_int(), 0);
        end
        square_wave_enable = 1'b1;
        pulse_strobe();
        check("reenabled_mag", sample_mag(), 245760);

        // Envelope down: 3,2,1,0 then hold.
        freq = 11'd1024; duty = 2'd3; env_init = 4'd3; env_up = 1'b0; env_period = 3'd1;
        wait_fire();
        pulse_trigger();
        pulse_strobe();
        check("env_down_v3", sample_mag(), 49152);
        wait_fire(); pulse_strobe(); check("env_down_v2", sample_mag(), 32768);
        wait_fire(); pulse_strobe(); check("env_down_v1", sample_mag(), 16384);
        wait_fire(); pulse_strobe(); check("env_down_v0", sample_mag(), 0);
        wait_fire(); pulse_strobe(); check("env_down_hold", sample_mag(), 0);

        // Strobe and trigger together: sample uses the old (silent) volume.
        env_init = 4'd15; env_period = 3'd0;
        strobe = 1'b1; trigger = 1'b1;
        @(negedge clk);
        strobe = 1'b0; trigger = 1'b0;
        check("strig_old_state", sample_mag(), 0);
        check("strig_valid_1", int'(sample_valid), 1);
        @(negedge clk);
        check("strig_valid_0", int'(sample_valid), 0);
        pulse_strobe();
        check("strig_new_state", sample_mag(), 245760);

        // Envelope up saturates at 15.
        env_init = 4'd14; env_up = 1'b1; env_period = 3'd1;
        wait_fire();
        pulse_trigger();
        pulse_strobe();
        check("env_up_v14", sample_mag(), 229376);
        wait_fire(); pulse_strobe(); check("env_up_v15", sample_mag(), 245760);
        wait_fire(); pulse_strobe(); check("env_up_sat", sample_mag(), 245760);

        // Reset mid-note: silent until retriggered.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_sample", sample_int(), 0);
        check("rst_mid_valid", int'(sample_valid), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pulse_strobe();
            check("rst_mid_silent", sample_int(), 0);
        end
        pulse_trigger();
        pulse_strobe();
        check("rst_retrigger", sample_mag(), 229376);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
